// File: rtl/shape_reg_receiver.sv
// ---------------------------------------------------------------------------
// shape_reg_receiver
//
// Shape-side receiver for the scan/program stream from the coordinate
// generator.
//
// Program cycles whose x_in matches SHAPE_ID write a shadow register bank.
// When the program burst ends, the shadow bank is copied into the active bank,
// but only if it actually received a write during that burst.
//
// Scan cycles run through a two-stage pipeline that tests each pixel against
// the active rectangle. The result goes to the pixel combiner.
//
// Parameters
//   SHAPE_ID     11-bit shape address this instance answers to
//
// Ports
//   clk          system clock, all logic on posedge
//   rst_n        asynchronous active-low reset
//   program_in   1 = program write cycle, 0 = scan cycle
//   x_in         program: shape address, scan: pixel x
//   y_in         program: register address, scan: pixel y
//   data_in      program: write data, ignored while scanning
//   pix_valid    hit/colour_out/x_out/y_out belong to a scan pixel
//   x_out        pixel x aligned with hit
//   y_out        pixel y aligned with hit
//   hit          pixel lies inside the active rectangle and CTRL.en is set
//   colour_out   active COLOUR when hit, else 0
//   cfg_pending  shadow bank holds uncommitted writes
//   bad_addr     sticky flag, a matching write used a register address > 5
//
// Register map (y_in while programming)
//   0 X_MIN[10:0]   1 X_MAX[10:0]   2 Y_MIN[11:0]
//   3 Y_MAX[11:0]   4 COLOUR[11:0]  5 CTRL[0] = en
// ---------------------------------------------------------------------------
module shape_reg_receiver #(
  parameter logic [10:0] SHAPE_ID = 11'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        program_in,
  input  logic [10:0] x_in,
  input  logic [11:0] y_in,
  input  logic [11:0] data_in,
  output logic        pix_valid,
  output logic [10:0] x_out,
  output logic [11:0] y_out,
  output logic        hit,
  output logic [11:0] colour_out,
  output logic        cfg_pending,
  output logic        bad_addr
);

  localparam logic [2:0] REG_X_MIN  = 3'd0;
  localparam logic [2:0] REG_X_MAX  = 3'd1;
  localparam logic [2:0] REG_Y_MIN  = 3'd2;
  localparam logic [2:0] REG_Y_MAX  = 3'd3;
  localparam logic [2:0] REG_COLOUR = 3'd4;
  localparam logic [2:0] REG_CTRL   = 3'd5;

  // Shadow bank: written during program bursts.
  logic [10:0] sh_x_min, sh_x_max;
  logic [11:0] sh_y_min, sh_y_max, sh_colour;
  logic        sh_en;

  // Active bank: used by the hit test.
  logic [10:0] ac_x_min, ac_x_max;
  logic [11:0] ac_y_min, ac_y_max, ac_colour;
  logic        ac_en;

  logic        prog_d;

  // Stage-1 pixel registers.
  logic [10:0] x1;
  logic [11:0] y1;
  logic        v1;

  logic        wr_match;
  logic        wr_valid;
  logic        wr_bad;
  logic        commit_edge;
  logic        in_rect;

  // A write is accepted only when its shape address matches this instance.
  // Register addresses above 5 are flagged and change nothing.
  assign wr_match    = program_in && (x_in == SHAPE_ID);
  assign wr_valid    = wr_match && (y_in <= 12'd5);
  assign wr_bad      = wr_match && (y_in > 12'd5);

  // The burst ends on the first scan cycle after a program cycle.
  assign commit_edge = prog_d && !program_in;

  // Shadow bank writes. The bank is never cleared by a commit, so a later
  // burst only needs to carry the registers it changes.
  // wr_valid guarantees that y_in <= 5, so the low three bits select the
  // register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_x_min  <= '0;
      sh_x_max  <= '0;
      sh_y_min  <= '0;
      sh_y_max  <= '0;
      sh_colour <= '0;
      sh_en     <= 1'b0;
    end else if (wr_valid) begin
      case (y_in[2:0])
        REG_X_MIN:  sh_x_min  <= data_in[10:0];
        REG_X_MAX:  sh_x_max  <= data_in[10:0];
        REG_Y_MIN:  sh_y_min  <= data_in;
        REG_Y_MAX:  sh_y_max  <= data_in;
        REG_COLOUR: sh_colour <= data_in;
        REG_CTRL:   sh_en     <= data_in[0];
        default:    ;
      endcase
    end
  end

  // Burst tracking and status flags.
  // A commit edge never coincides with a write, because a commit edge needs
  // program_in low. The set and clear of cfg_pending therefore cannot collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_d      <= 1'b0;
      cfg_pending <= 1'b0;
      bad_addr    <= 1'b0;
    end else begin
      prog_d <= program_in;
      if (wr_valid)
        cfg_pending <= 1'b1;
      else if (commit_edge)
        cfg_pending <= 1'b0;
      if (wr_bad)
        bad_addr <= 1'b1;
    end
  end

  // Active bank update.
  // The active bank changes on the same edge that captures the first
  // post-burst pixel into stage 1. Every later S2 compare therefore sees one
  // consistent configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac_x_min  <= '0;
      ac_x_max  <= '0;
      ac_y_min  <= '0;
      ac_y_max  <= '0;
      ac_colour <= '0;
      ac_en     <= 1'b0;
    end else if (commit_edge && cfg_pending) begin
      ac_x_min  <= sh_x_min;
      ac_x_max  <= sh_x_max;
      ac_y_min  <= sh_y_min;
      ac_y_max  <= sh_y_max;
      ac_colour <= sh_colour;
      ac_en     <= sh_en;
    end
  end

  // Stage 1: register the incoming coordinate and whether it is a pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x1 <= '0;
      y1 <= '0;
      v1 <= 1'b0;
    end else begin
      x1 <= x_in;
      y1 <= y_in;
      v1 <= !program_in;
    end
  end

  // Inclusive unsigned bounds. Inverted bounds make this false for every
  // pixel, which gives the empty rectangle.
  assign in_rect = (x1 >= ac_x_min) && (x1 <= ac_x_max) &&
                   (y1 >= ac_y_min) && (y1 <= ac_y_max) && ac_en;

  // Stage 2: registered outputs.
  // On bubbles, hit and colour are forced low and x_out/y_out hold the last
  // pixel's coordinates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid  <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      hit        <= 1'b0;
      colour_out <= '0;
    end else begin
      pix_valid <= v1;
      if (v1) begin
        x_out <= x1;
        y_out <= y1;
      end
      hit        <= v1 && in_rect;
      colour_out <= (v1 && in_rect) ? ac_colour : 12'd0;
    end
  end

endmodule

// File: tb/tb_shape_reg_receiver.sv
// ---------------------------------------------------------------------------
// tb_shape_reg_receiver
//
// Directed bench for shape_reg_receiver with SHAPE_ID = 3.
//
// A reference model of the register banks runs alongside the stimulus. Each
// driven cycle pushes its expected pipeline output into a queue. That entry
// is popped and compared two clock edges later.
//
// The burst status flags are compared every cycle against the same model.
// ---------------------------------------------------------------------------
module tb_shape_reg_receiver;

  localparam logic [10:0] SHAPE_ID = 11'd3;
  localparam logic [10:0] OTHER_ID = 11'h7FF;

  logic        clk;
  logic        rst_n;
  logic        program_in;
  logic [10:0] x_in;
  logic [11:0] y_in;
  logic [11:0] data_in;
  logic        pix_valid;
  logic [10:0] x_out;
  logic [11:0] y_out;
  logic        hit;
  logic [11:0] colour_out;
  logic        cfg_pending;
  logic        bad_addr;

  shape_reg_receiver #(.SHAPE_ID(SHAPE_ID)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .program_in  (program_in),
    .x_in        (x_in),
    .y_in        (y_in),
    .data_in     (data_in),
    .pix_valid   (pix_valid),
    .x_out       (x_out),
    .y_out       (y_out),
    .hit         (hit),
    .colour_out  (colour_out),
    .cfg_pending (cfg_pending),
    .bad_addr    (bad_addr)
  );

  typedef struct {
    int          cyc;
    logic        valid;
    logic [10:0] x;
    logic [11:0] y;
    logic        hit;
    logic [11:0] colour;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc_count = 0;

  // Reference model state.
  logic [11:0] m_shadow[6];
  logic [11:0] m_active[6];
  logic        m_pending;
  logic        m_bad;
  logic        m_prog_d;
  logic [10:0] m_last_x;
  logic [11:0] m_last_y;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_count <= cyc_count + 1;

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 6; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_pending = 1'b0;
    m_bad     = 1'b0;
    m_prog_d  = 1'b0;
    m_last_x  = '0;
    m_last_y  = '0;
    exp_q.delete();
  endtask

  // Compare the flags every cycle. Compare the pipeline outputs whenever the
  // oldest queued entry has had two edges to emerge.
  task automatic checkOutput();
    exp_t e;
    compare("cfg_pending", {31'd0, cfg_pending}, {31'd0, m_pending});
    compare("bad_addr", {31'd0, bad_addr}, {31'd0, m_bad});
    if (exp_q.size() > 0 && exp_q[0].cyc + 2 <= cyc_count) begin
      e = exp_q.pop_front();
      compare("pix_valid", {31'd0, pix_valid}, {31'd0, e.valid});
      compare("hit", {31'd0, hit}, {31'd0, e.hit});
      compare("colour_out", {20'd0, colour_out}, {20'd0, e.colour});
      compare("x_out", {21'd0, x_out}, {21'd0, e.x});
      compare("y_out", {20'd0, y_out}, {20'd0, e.y});
    end
  endtask

  // Drive one cycle and advance the model to the state after the next edge.
  task automatic applyStimulus(input logic prog, input logic [10:0] x,
                               input logic [11:0] y, input logic [11:0] data);
    exp_t e;
    @(negedge clk);
    checkOutput();
    program_in = prog;
    x_in       = x;
    y_in       = y;
    data_in    = data;
    if (m_prog_d && !prog) begin
      if (m_pending)
        for (int i = 0; i < 6; i++) m_active[i] = m_shadow[i];
      m_pending = 1'b0;
    end
    if (prog && x == SHAPE_ID) begin
      if (y <= 12'd5) begin
        case (y)
          12'd0, 12'd1: m_shadow[y] = {1'b0, data[10:0]};
          12'd5:        m_shadow[y] = {11'd0, data[0]};
          default:      m_shadow[y] = data;
        endcase
        m_pending = 1'b1;
      end else begin
        m_bad = 1'b1;
      end
    end
    m_prog_d = prog;
    e.cyc   = cyc_count;
    e.valid = !prog;
    if (!prog) begin
      m_last_x = x;
      m_last_y = y;
    end
    e.x   = m_last_x;
    e.y   = m_last_y;
    e.hit = !prog && m_active[5][0] &&
            ({1'b0, x} >= m_active[0]) && ({1'b0, x} <= m_active[1]) &&
            (y >= m_active[2]) && (y <= m_active[3]);
    e.colour = e.hit ? m_active[4] : 12'd0;
    exp_q.push_back(e);
  endtask

  task automatic scanRow(input logic [11:0] y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) applyStimulus(1'b0, x[10:0], y, 12'd0);
  endtask

  // Assert reset asynchronously and confirm every output clears at once.
  // The idle cycle after release is a non-matching program cycle, so the
  // DUT leaves reset with prog_d set.
  task automatic applyReset();
    @(negedge clk);
    rst_n      = 1'b0;
    program_in = 1'b1;
    x_in       = OTHER_ID;
    y_in       = '0;
    data_in    = '0;
    #1;
    compare("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
    compare("rst_hit", {31'd0, hit}, 32'd0);
    compare("rst_colour", {20'd0, colour_out}, 32'd0);
    compare("rst_x_out", {21'd0, x_out}, 32'd0);
    compare("rst_y_out", {20'd0, y_out}, 32'd0);
    compare("rst_cfg_pending", {31'd0, cfg_pending}, 32'd0);
    compare("rst_bad_addr", {31'd0, bad_addr}, 32'd0);
    modelReset();
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    m_prog_d = 1'b1;
  endtask

  task automatic programMain();
    applyStimulus(1'b1, SHAPE_ID, 12'd0, 12'd10);
    applyStimulus(1'b1, SHAPE_ID, 12'd1, 12'd20);
    applyStimulus(1'b1, SHAPE_ID, 12'd2, 12'd5);
    applyStimulus(1'b1, SHAPE_ID, 12'd3, 12'd6);
    applyStimulus(1'b1, SHAPE_ID, 12'd4, 12'hF00);
    applyStimulus(1'b1, SHAPE_ID, 12'd5, 12'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    program_in = 1'b0;
    x_in       = '0;
    y_in       = '0;
    data_in    = '0;
    modelReset();
    applyReset();

    // Main configuration, then scan a row that crosses the rectangle.
    programMain();
    scanRow(12'd5, 0, 30);

    // Reset in the middle of a scan row, inside the rectangle.
    scanRow(12'd5, 0, 15);
    applyReset();
    scanRow(12'd5, 0, 30);

    // Reprogram, then send writes addressed to another shape.
    programMain();
    scanRow(12'd6, 8, 22);
    applyStimulus(1'b1, 11'd4, 12'd0, 12'd0);
    applyStimulus(1'b1, 11'd4, 12'd1, 12'd30);
    applyStimulus(1'b1, 11'd4, 12'd5, 12'd0);
    scanRow(12'd5, 0, 30);

    // One-cycle burst that writes X_MIN only, leaving an empty rectangle.
    applyStimulus(1'b1, SHAPE_ID, 12'd0, 12'd25);
    scanRow(12'd5, 0, 30);

    // Single-pixel rectangle at (12,5).
    applyStimulus(1'b1, SHAPE_ID, 12'd0, 12'd12);
    applyStimulus(1'b1, SHAPE_ID, 12'd1, 12'd12);
    applyStimulus(1'b1, SHAPE_ID, 12'd3, 12'd5);
    for (int y = 4; y <= 6; y++) scanRow(y[11:0], 10, 14);

    // Out-of-range register address: sticky flag, map untouched.
    applyStimulus(1'b1, SHAPE_ID, 12'd7, 12'd0);
    scanRow(12'd5, 10, 14);
    applyStimulus(1'b1, OTHER_ID, 12'd0, 12'd0);
    scanRow(12'd5, 11, 13);

    // Disable the shape.
    applyStimulus(1'b1, SHAPE_ID, 12'd5, 12'd0);
    scanRow(12'd5, 10, 14);

    // Reset between writes of a burst, then end the burst.
    applyStimulus(1'b1, SHAPE_ID, 12'd0, 12'd10);
    applyStimulus(1'b1, SHAPE_ID, 12'd5, 12'd1);
    applyReset();
    applyStimulus(1'b1, 11'd4, 12'd1, 12'd20);
    scanRow(12'd5, 0, 30);

    repeat (3) begin
      @(negedge clk);
      checkOutput();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
